tri_raster_scan: RTL



---
 rtl/tri_raster_pkg.sv | 58 +++++
 rtl/tri_edge_eval.sv | 34 +++
 rtl/tri_raster_scan.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tri_raster_pkg.sv
// Shared widths, FSM state type, point type and arithmetic helpers for the
// triangle scan-conversion front end.
package tri_raster_pkg;

  localparam int COORD_W = 12;
  localparam int EDGE_W  = 27;
  localparam int DIFF_W  = COORD_W + 1;
  localparam int PROD_W  = 2 * DIFF_W;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                              input logic [COORD_W-1:0] b,
                                              input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // E(a,b,p) = (px-bx)(ay-by) - (ax-bx)(py-by), kept at full precision.
  function automatic logic signed [EDGE_W-1:0] edge_fn(input point_t a,
                                                       input point_t b,
                                                       input point_t p);
    logic signed [DIFF_W-1:0] dpx;
    logic signed [DIFF_W-1:0] day;
    logic signed [DIFF_W-1:0] dax;
    logic signed [DIFF_W-1:0] dpy;
    logic signed [PROD_W-1:0] m0;
    logic signed [PROD_W-1:0] m1;
    dpx = $signed({1'b0, p.x}) - $signed({1'b0, b.x});
    day = $signed({1'b0, a.y}) - $signed({1'b0, b.y});
    dax = $signed({1'b0, a.x}) - $signed({1'b0, b.x});
    dpy = $signed({1'b0, p.y}) - $signed({1'b0, b.y});
    m0  = PROD_W'(dpx) * PROD_W'(day);
    m1  = PROD_W'(dax) * PROD_W'(dpy);
    return $signed({m0[PROD_W-1], m0}) - $signed({m1[PROD_W-1], m1});
  endfunction

endpackage

// File: rtl/tri_edge_eval.sv
// Combinational coverage test of one point against the three triangle edges
// (v1,v2), (v2,v3), (v3,v1); covered when every edge function is >= 0.
module tri_edge_eval
  import tri_raster_pkg::*;
(
  input  logic [COORD_W-1:0] i_v1x,
  input  logic [COORD_W-1:0] i_v1y,
  input  logic [COORD_W-1:0] i_v2x,
  input  logic [COORD_W-1:0] i_v2y,
  input  logic [COORD_W-1:0] i_v3x,
  input  logic [COORD_W-1:0] i_v3y,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  output logic               o_covered
);

  point_t                   w_vtx [3];
  point_t                   w_pt;
  logic signed [EDGE_W-1:0] w_edge [3];
  logic [2:0]               w_inside;

  assign w_vtx[0] = '{x: i_v1x, y: i_v1y};
  assign w_vtx[1] = '{x: i_v2x, y: i_v2y};
  assign w_vtx[2] = '{x: i_v3x, y: i_v3y};
  assign w_pt     = '{x: i_px,  y: i_py};

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    assign w_edge[gi]   = edge_fn(w_vtx[gi], w_vtx[(gi + 1) % 3], w_pt);
    assign w_inside[gi] = ~w_edge[gi][EDGE_W-1];
  end

  assign o_covered = &w_inside;

endmodule

// File: rtl/tri_raster_scan.sv
// Triangle scan conversion: latches a triangle, sweeps its bounding box in raster
// order and streams covered pixels. Define TRI_RASTER_CLAMP_EN to clamp the box
// to SCREEN_W x SCREEN_H (otherwise the full 12-bit box is scanned).
module tri_raster_scan
  import tri_raster_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [COORD_W-1:0] v1x,
  input  logic [COORD_W-1:0] v1y,
  input  logic [COORD_W-1:0] v2x,
  input  logic [COORD_W-1:0] v2y,
  input  logic [COORD_W-1:0] v3x,
  input  logic [COORD_W-1:0] v3y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               tri_done
);

`ifdef TRI_RASTER_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  state_t             r_state;
  point_t             r_vtx [3];
  logic [COORD_W-1:0] r_xmin;
  logic [COORD_W-1:0] r_xmax;
  logic [COORD_W-1:0] r_ymax;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_pix_valid;
  logic [COORD_W-1:0] r_pix_x;
  logic [COORD_W-1:0] r_pix_y;

  point_t             w_in_vtx [3];
  logic [COORD_W-1:0] w_xmin;
  logic [COORD_W-1:0] w_ymin;
  logic [COORD_W-1:0] w_xmax_raw;
  logic [COORD_W-1:0] w_ymax_raw;
  logic [COORD_W-1:0] w_xmax;
  logic [COORD_W-1:0] w_ymax;
  logic               w_box_empty;
  logic               w_accept;
  logic               w_stall;
  logic               w_advance;
  logic               w_row_end;
  logic               w_last_pt;
  logic               w_covered;

  assign w_in_vtx[0] = '{x: v1x, y: v1y};
  assign w_in_vtx[1] = '{x: v2x, y: v2y};
  assign w_in_vtx[2] = '{x: v3x, y: v3y};

  assign w_accept  = tri_valid && (r_state == IDLE);
  assign w_stall   = r_pix_valid && !pix_ready;
  assign w_advance = (r_state == SCAN) && !w_stall;
  assign w_row_end = (r_x == r_xmax);
  assign w_last_pt = w_row_end && (r_y == r_ymax);

  // Bounding box from the latched vertices; only the max edges can leave the screen.
  assign w_xmin     = min3(r_vtx[0].x, r_vtx[1].x, r_vtx[2].x);
  assign w_ymin     = min3(r_vtx[0].y, r_vtx[1].y, r_vtx[2].y);
  assign w_xmax_raw = max3(r_vtx[0].x, r_vtx[1].x, r_vtx[2].x);
  assign w_ymax_raw = max3(r_vtx[0].y, r_vtx[1].y, r_vtx[2].y);
  assign w_xmax     = (CLAMP_EN && (w_xmax_raw > X_LIM)) ? X_LIM : w_xmax_raw;
  assign w_ymax     = (CLAMP_EN && (w_ymax_raw > Y_LIM)) ? Y_LIM : w_ymax_raw;
  assign w_box_empty = (w_xmin > w_xmax) || (w_ymin > w_ymax);

  tri_edge_eval u_edge_eval (
    .i_v1x     (r_vtx[0].x),
    .i_v1y     (r_vtx[0].y),
    .i_v2x     (r_vtx[1].x),
    .i_v2y     (r_vtx[1].y),
    .i_v3x     (r_vtx[2].x),
    .i_v3y     (r_vtx[2].y),
    .i_px      (r_x),
    .i_py      (r_y),
    .o_covered (w_covered)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_state <= SETUP;
        SETUP:   r_state <= w_box_empty ? DONE : SCAN;
        SCAN:    if (w_advance && w_last_pt) r_state <= DRAIN;
        DRAIN:   if (!r_pix_valid || pix_ready) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_vtx[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_vtx[i] <= w_in_vtx[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymax <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (r_state == SETUP) begin
      r_xmin <= w_xmin;
      r_xmax <= w_xmax;
      r_ymax <= w_ymax;
      r_x    <= w_xmin;
      r_y    <= w_ymin;
    end else if (w_advance) begin
      if (w_row_end) begin
        r_x <= r_xmin;
        if (!w_last_pt) r_y <= r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  // Output register: a new pixel may load in the same cycle the old one is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else if (w_advance) begin
      r_pix_valid <= w_covered;
      if (w_covered) begin
        r_pix_x <= r_x;
        r_pix_y <= r_y;
      end
    end else if ((r_state == DRAIN) && pix_ready) begin
      r_pix_valid <= 1'b0;
    end
  end

  assign tri_ready = (r_state == IDLE);
  assign tri_done  = (r_state == DONE);
  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;

endmodule
